accelerator_vector_integration_feeder: RTL
==========================================

Name: accelerator_vector_integration_feeder

Overview:
- Upstream stage of the vector integration accelerator.
- Buffers incoming vector samples in a FIFO and latches the run configuration (size, period, length).
- Starts the integrator, then streams the elements to it one per request, tagging vector boundaries.
- Reports completion once the integrator signals ready.

Parameters:
DATA_SIZE, 64, width of data, configuration and counter words
CONTROL_SIZE, 64, passed through for codebase consistency; no internal use
FIFO_DEPTH, 16, FIFO entries; power of two, at least 2; ADDR_SIZE = log2(FIFO_DEPTH)

Ports:
CLK  in  1  clock
RST  in  1  asynchronous, active-high reset
START  in  1  start of run; sampled in IDLE only
READY  out  1  one-cycle pulse at end of run
WRITE_ENABLE  in  1  push DATA_IN into the FIFO
DATA_IN  in  DATA_SIZE  sample from producer
FULL  out  1  FIFO occupancy == FIFO_DEPTH
EMPTY  out  1  FIFO occupancy == 0
COUNT  out  ADDR_SIZE+1  FIFO occupancy
SIZE_IN / PERIOD_IN / LENGTH_IN  in  DATA_SIZE each  run configuration; SIZE = vectors, LENGTH = elements per vector
SIZE_OUT / PERIOD_OUT / LENGTH_OUT  out  DATA_SIZE each  latched configuration to integrator
INTEGRATION_START  out  1  one-cycle start pulse to integrator
INTEGRATION_READY  in  1  integrator finished
ELEMENT_REQUEST  in  1  integrator asks for next element
DATA_OUT  out  DATA_SIZE  element to integrator
DATA_OUT_VECTOR_ENABLE  out  1  DATA_OUT valid; one-cycle pulse per element
DATA_OUT_SCALAR_ENABLE  out  1  pulses together with the first element of each vector

Behaviour:
- Reset: all outputs 0 except EMPTY=1; FIFO flushed; counters and pending flag cleared; state IDLE. Reset mid-run aborts the run with no READY pulse.
- FIFO operation, independent of FSM state, writes accepted in any state:
  - Push when WRITE_ENABLE && !FULL. A push while FULL is dropped, even if a pop occurs in the same cycle.
  - A push into an empty FIFO is poppable from the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - COUNT, FULL and EMPTY are registered and reflect the state after the current edge.
- IDLE: on START, latch SIZE_IN/PERIOD_IN/LENGTH_IN into the *_OUT ports, clear element index e and vector index v, and pulse INTEGRATION_START for one cycle. Next state is STREAM, or END if SIZE==0 or LENGTH==0.
- STREAM:
  - An ELEMENT_REQUEST while EMPTY sets a single sticky pending flag; extra requests do not accumulate.
  - Pop when (ELEMENT_REQUEST || pending) && !EMPTY. On the next cycle DATA_OUT = popped word, DATA_OUT_VECTOR_ENABLE=1 and DATA_OUT_SCALAR_ENABLE=(e==0); pending clears.
  - Latency from request to data is 1 cycle; back-to-back requests give one element per cycle.
  - Counters: e++ per pop; when e==LENGTH-1, e wraps to 0 and v++.
  - The pop with v==SIZE-1 && e==LENGTH-1 moves the FSM to END.
  - Requests in other states are ignored.
- END: wait for INTEGRATION_READY, then pulse READY for one cycle and return to IDLE. Extra FIFO contents are retained for the next run.
- START in STREAM or END is ignored.
- DATA_OUT holds its last value between pulses; both enables are 0 outside pulses.
- Counters are DATA_SIZE wide and compared at full width; no saturation.

Optional Feature:
ACCELERATOR_VECTOR_INTEGRATION_FEEDER_OVERFLOW_EN
- Defined: adds output OVERFLOW (1 bit), reset 0. It is set sticky on any push attempt while FULL and cleared on an accepted START.
- Undefined: no OVERFLOW port; dropped pushes are silent. All other behaviour is identical.

Test Plan:
- Push 4 words 0x10..0x13; START with SIZE=2, LENGTH=2; single requests each 3 cycles.
  - Expected: INTEGRATION_START pulses once; DATA_OUT sequence 0x10,0x11,0x12,0x13; SCALAR_ENABLE on 0x10 and 0x12 only.
  - Then INTEGRATION_READY=1 gives READY one cycle later, FSM returns to IDLE.
- FIFO_DEPTH=16: push 17 words.
  - Expected: FULL=1, COUNT=16, 17th word dropped. With the macro, OVERFLOW=1 until the next START.
- Empty FIFO in STREAM: 3 requests, then push 0xAA.
  - Expected: exactly one VECTOR_ENABLE pulse carrying 0xAA; no further pulses.
- START with LENGTH=0.
  - Expected: INTEGRATION_START pulses, no data pulses, READY pulses after INTEGRATION_READY.
- Continuous ELEMENT_REQUEST with 8 words preloaded, SIZE=1, LENGTH=8.
  - Expected: 8 consecutive-cycle pulses, COUNT falls 8→0.
- RST asserted mid-STREAM after 2 of 4 elements.
  - Expected: outputs 0, EMPTY=1, no READY; a new START runs cleanly from e=v=0.

Source files
------------

// File: rtl/accelerator_vector_integration_feeder.sv
// -----------------------------------------------------------------------------
// accelerator_vector_integration_feeder
//
// Upstream stage of the vector integration accelerator. Samples from the
// producer are buffered in a FIFO. On START the run configuration is latched
// and the integrator is kicked. Elements are then streamed to it one per
// request, with the first element of each vector tagged. READY pulses once
// the integrator reports completion.
//
// Ports:
//   CLK, RST                         clock, asynchronous active-high reset
//   START / READY                    run start (IDLE only) / end-of-run pulse
//   WRITE_ENABLE, DATA_IN            producer push interface
//   FULL, EMPTY, COUNT               registered FIFO status
//   SIZE_IN/PERIOD_IN/LENGTH_IN      run configuration
//   SIZE_OUT/PERIOD_OUT/LENGTH_OUT   latched configuration to integrator
//   INTEGRATION_START                one-cycle start pulse to integrator
//   INTEGRATION_READY                integrator finished
//   ELEMENT_REQUEST                  integrator asks for next element
//   DATA_OUT, DATA_OUT_VECTOR_ENABLE element and its valid pulse
//   DATA_OUT_SCALAR_ENABLE           pulses with the first element of a vector
//
// Optional feature macro: ACCELERATOR_VECTOR_INTEGRATION_FEEDER_OVERFLOW_EN
//   When defined, adds OVERFLOW: sticky flag set by any push attempt while
//   FULL, cleared by an accepted START.
// -----------------------------------------------------------------------------
module accelerator_vector_integration_feeder #(
    parameter int unsigned DATA_SIZE    = 64,
    parameter int unsigned CONTROL_SIZE = 64,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          START,
    output logic                          READY,
    input  logic                          WRITE_ENABLE,
    input  logic [DATA_SIZE-1:0]          DATA_IN,
    output logic                          FULL,
    output logic                          EMPTY,
    output logic [$clog2(FIFO_DEPTH):0]   COUNT,
    input  logic [DATA_SIZE-1:0]          SIZE_IN,
    input  logic [DATA_SIZE-1:0]          PERIOD_IN,
    input  logic [DATA_SIZE-1:0]          LENGTH_IN,
    output logic [DATA_SIZE-1:0]          SIZE_OUT,
    output logic [DATA_SIZE-1:0]          PERIOD_OUT,
    output logic [DATA_SIZE-1:0]          LENGTH_OUT,
    output logic                          INTEGRATION_START,
    input  logic                          INTEGRATION_READY,
    input  logic                          ELEMENT_REQUEST,
    output logic [DATA_SIZE-1:0]          DATA_OUT,
    output logic                          DATA_OUT_VECTOR_ENABLE,
    output logic                          DATA_OUT_SCALAR_ENABLE
`ifdef ACCELERATOR_VECTOR_INTEGRATION_FEEDER_OVERFLOW_EN
    ,
    output logic                          OVERFLOW
`endif
);

    // CONTROL_SIZE has no internal use; folded in as a zero term so it is referenced.
    localparam int unsigned AW = $clog2(FIFO_DEPTH) + 0 * CONTROL_SIZE;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_END
    } state_t;

    state_t                 state_q;
    logic [DATA_SIZE-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q;
    logic [AW-1:0]          rd_ptr_q;
    logic [CW-1:0]          count_q;
    logic [CW-1:0]          count_d;
    logic                   full_q;
    logic                   empty_q;
    logic [DATA_SIZE-1:0]   size_q;
    logic [DATA_SIZE-1:0]   period_q;
    logic [DATA_SIZE-1:0]   length_q;
    logic [DATA_SIZE-1:0]   elem_q;
    logic [DATA_SIZE-1:0]   vec_q;
    logic                   pending_q;
    logic [DATA_SIZE-1:0]   data_q;
    logic                   vec_en_q;
    logic                   scl_en_q;
    logic                   istart_q;
    logic                   ready_q;
`ifdef ACCELERATOR_VECTOR_INTEGRATION_FEEDER_OVERFLOW_EN
    logic                   overflow_q;
`endif

    logic push_en;
    logic pop_en;
    logic last_elem;
    logic last_vec;

    // A push while FULL is dropped even if a pop frees a slot this cycle.
    assign push_en   = WRITE_ENABLE && !full_q;
    assign pop_en    = (state_q == S_STREAM) && (ELEMENT_REQUEST || pending_q) && !empty_q;
    assign last_elem = (elem_q == length_q - DATA_SIZE'(1));
    assign last_vec  = (vec_q == size_q - DATA_SIZE'(1));

    // Occupancy after this edge.
    always_comb begin
        count_d = count_q;
        if (push_en && !pop_en) begin
            count_d = count_q + CW'(1);
        end else if (!push_en && pop_en) begin
            count_d = count_q - CW'(1);
        end
    end

    // FIFO storage; contents need no reset since the pointers are flushed.
    always_ff @(posedge CLK) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= DATA_IN;
        end
    end

    // FIFO pointers, run control FSM and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            size_q     <= '0;
            period_q   <= '0;
            length_q   <= '0;
            elem_q     <= '0;
            vec_q      <= '0;
            pending_q  <= 1'b0;
            data_q     <= '0;
            vec_en_q   <= 1'b0;
            scl_en_q   <= 1'b0;
            istart_q   <= 1'b0;
            ready_q    <= 1'b0;
`ifdef ACCELERATOR_VECTOR_INTEGRATION_FEEDER_OVERFLOW_EN
            overflow_q <= 1'b0;
`endif
        end else begin
            vec_en_q <= 1'b0;
            scl_en_q <= 1'b0;
            istart_q <= 1'b0;
            ready_q  <= 1'b0;

            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CW'(FIFO_DEPTH));
            empty_q <= (count_d == '0);

            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        size_q    <= SIZE_IN;
                        period_q  <= PERIOD_IN;
                        length_q  <= LENGTH_IN;
                        elem_q    <= '0;
                        vec_q     <= '0;
                        pending_q <= 1'b0;
                        istart_q  <= 1'b1;
`ifdef ACCELERATOR_VECTOR_INTEGRATION_FEEDER_OVERFLOW_EN
                        overflow_q <= 1'b0;
`endif
                        // Degenerate run: nothing to stream, go straight to completion wait.
                        if (SIZE_IN == '0 || LENGTH_IN == '0) begin
                            state_q <= S_END;
                        end else begin
                            state_q <= S_STREAM;
                        end
                    end
                end
                S_STREAM: begin
                    if (pop_en) begin
                        data_q    <= mem_q[rd_ptr_q];
                        vec_en_q  <= 1'b1;
                        scl_en_q  <= (elem_q == '0);
                        pending_q <= 1'b0;
                        if (last_elem) begin
                            elem_q <= '0;
                            vec_q  <= vec_q + DATA_SIZE'(1);
                            if (last_vec) begin
                                state_q <= S_END;
                            end
                        end else begin
                            elem_q <= elem_q + DATA_SIZE'(1);
                        end
                    end else if (ELEMENT_REQUEST) begin
                        // Only reachable while EMPTY: remember one outstanding request.
                        pending_q <= 1'b1;
                    end
                end
                S_END: begin
                    if (INTEGRATION_READY) begin
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

`ifdef ACCELERATOR_VECTOR_INTEGRATION_FEEDER_OVERFLOW_EN
            if (WRITE_ENABLE && full_q) begin
                overflow_q <= 1'b1;
            end
`endif
        end
    end

    assign READY                  = ready_q;
    assign FULL                   = full_q;
    assign EMPTY                  = empty_q;
    assign COUNT                  = count_q;
    assign SIZE_OUT               = size_q;
    assign PERIOD_OUT             = period_q;
    assign LENGTH_OUT             = length_q;
    assign INTEGRATION_START      = istart_q;
    assign DATA_OUT               = data_q;
    assign DATA_OUT_VECTOR_ENABLE = vec_en_q;
    assign DATA_OUT_SCALAR_ENABLE = scl_en_q;
`ifdef ACCELERATOR_VECTOR_INTEGRATION_FEEDER_OVERFLOW_EN
    assign OVERFLOW               = overflow_q;
`endif

endmodule
